// File: rtl/alu_seq_pkg.sv
// Shared state type and command-word layout for the ALU command sequencer.
// Command word: {ALU_OP[12:10], W_Addr[9:5], R_Addr_B[4:0]}.
package alu_seq_pkg;

    localparam int CMD_W          = 13;
    localparam int OP_W           = 3;
    localparam int FIELD_ADDR_W   = 5;
    localparam int ADDR_W_DEFAULT = 5;
    localparam int OP_LSB         = 10;
    localparam int WA_LSB         = 5;
    localparam int RB_LSB         = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic logic [OP_W-1:0] cmd_op(input logic [CMD_W-1:0] cmd);
        return cmd[OP_LSB +: OP_W];
    endfunction

    function automatic logic [FIELD_ADDR_W-1:0] cmd_waddr(input logic [CMD_W-1:0] cmd);
        return cmd[WA_LSB +: FIELD_ADDR_W];
    endfunction

    function automatic logic [FIELD_ADDR_W-1:0] cmd_raddr_b(input logic [CMD_W-1:0] cmd);
        return cmd[RB_LSB +: FIELD_ADDR_W];
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: DEPTH x CMD_W, synchronous write,
// asynchronous read so the next command can be registered in the same cycle.
module seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [CMD_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [CMD_W-1:0]         rdata
);

    logic [CMD_W-1:0] mem_q [DEPTH];

    // NOTE: no reset on the array; program contents survive Reset and it maps onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Start/busy/done command sequencer feeding the register-file/ALU datapath.
// Optional build macro SEQ_HALT_ON_OF_EN: abort the run after a write that flags overflow.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [CMD_W-1:0]              prog_data,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    input  logic                          OF,
    input  logic                          ZF,
    output logic [ADDR_W-1:0]             R_Addr_A,
    output logic [ADDR_W-1:0]             R_Addr_B,
    output logic [ADDR_W-1:0]             W_Addr,
    output logic [OP_W-1:0]               ALU_OP,
    output logic                          Write_Reg,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(PROG_DEPTH):0]   pc,
    output logic                          of_seen,
    output logic                          zf_last,
    output logic                          halted
);

    localparam int PA_W = $clog2(PROG_DEPTH);
    localparam int PC_W = PA_W + 1;
    localparam logic [PC_W-1:0] DEPTH_C = PC_W'(PROG_DEPTH);

    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0] r_addr_a_q, r_addr_a_d;
    logic [ADDR_W-1:0] r_addr_b_q, r_addr_b_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              write_reg_q, write_reg_d;
    logic              of_seen_q, of_seen_d;
    logic              zf_last_q, zf_last_d;
    logic              halted_q, halted_d;

    logic [PC_W-1:0]   len_sat;
    logic              mem_we;
    logic [PA_W-1:0]   rd_addr;
    logic [CMD_W-1:0]  rd_data;
    logic              halt_req;

`ifdef SEQ_HALT_ON_OF_EN
    assign halt_req = OF;
`else
    assign halt_req = 1'b0;
`endif

    assign len_sat = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;
    assign mem_we  = prog_we && (state_q == ST_IDLE);

    // Read one entry ahead of pc so the next command lands in the output registers on time.
    assign rd_addr = (state_q == ST_RUN) ? (pc_q[PA_W-1:0] + PA_W'(1)) : '0;

    seq_prog_mem #(
        .DEPTH (PROG_DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case leaves a latch behind.
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        of_seen_d   = of_seen_q;
        zf_last_d   = zf_last_q;
        halted_d    = halted_q;
        r_addr_a_d  = '0;
        r_addr_b_d  = '0;
        w_addr_d    = '0;
        alu_op_d    = '0;
        write_reg_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_sat == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        len_d       = len_sat;
                        pc_d        = '0;
                        of_seen_d   = 1'b0;
                        zf_last_d   = 1'b0;
                        halted_d    = 1'b0;
                        alu_op_d    = cmd_op(rd_data);
                        w_addr_d    = ADDR_W'(cmd_waddr(rd_data));
                        r_addr_a_d  = ADDR_W'(cmd_waddr(rd_data));
                        r_addr_b_d  = ADDR_W'(cmd_raddr_b(rd_data));
                        write_reg_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                of_seen_d = of_seen_q | OF;
                zf_last_d = ZF;
                pc_d      = pc_q + PC_W'(1);
                if ((pc_d == len_q) || halt_req) begin
                    state_d  = ST_DONE;
                    halted_d = halt_req;
                end else begin
                    // Chain through the accumulator: A reads what the previous command wrote.
                    alu_op_d    = cmd_op(rd_data);
                    w_addr_d    = ADDR_W'(cmd_waddr(rd_data));
                    r_addr_a_d  = w_addr_q;
                    r_addr_b_d  = ADDR_W'(cmd_raddr_b(rd_data));
                    write_reg_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            r_addr_a_q  <= '0;
            r_addr_b_q  <= '0;
            w_addr_q    <= '0;
            alu_op_q    <= '0;
            write_reg_q <= 1'b0;
            of_seen_q   <= 1'b0;
            zf_last_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            r_addr_a_q  <= r_addr_a_d;
            r_addr_b_q  <= r_addr_b_d;
            w_addr_q    <= w_addr_d;
            alu_op_q    <= alu_op_d;
            write_reg_q <= write_reg_d;
            of_seen_q   <= of_seen_d;
            zf_last_q   <= zf_last_d;
            halted_q    <= halted_d;
        end
    end

    assign R_Addr_A  = r_addr_a_q;
    assign R_Addr_B  = r_addr_b_q;
    assign W_Addr    = w_addr_q;
    assign ALU_OP    = alu_op_q;
    assign Write_Reg = write_reg_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pc        = pc_q;
    assign of_seen   = of_seen_q;
    assign zf_last   = zf_last_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed corner runs plus random programs
// compared against a list-based model of the program execution.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int PA_W  = 4;
    localparam int PC_W  = 5;

`ifdef SEQ_HALT_ON_OF_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            Reset;
    logic            prog_we;
    logic [PA_W-1:0] prog_addr;
    logic [12:0]     prog_data;
    logic [PC_W-1:0] prog_len;
    logic            start;
    logic            OF;
    logic            ZF;
    logic [4:0]      R_Addr_A;
    logic [4:0]      R_Addr_B;
    logic [4:0]      W_Addr;
    logic [2:0]      ALU_OP;
    logic            Write_Reg;
    logic            busy;
    logic            done;
    logic [PC_W-1:0] pc;
    logic            of_seen;
    logic            zf_last;
    logic            halted;

    logic [12:0] prog_m [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .PROG_DEPTH (DEPTH),
        .ADDR_W     (5)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .OF        (OF),
        .ZF        (ZF),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .ALU_OP    (ALU_OP),
        .Write_Reg (Write_Reg),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .of_seen   (of_seen),
        .zf_last   (zf_last),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_entry(input int addr, input logic [12:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr[PA_W-1:0];
        prog_data = data;
        prog_m[addr] = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // Runs one program of length len; of_mask/zf_bits give the flags returned for command i.
    task automatic run_prog(input string tag, input int len, input logic [31:0] of_mask,
                            input logic [31:0] zf_bits, input bit inject);
        int          n;
        int          exp_cnt;
        int          done_at;
        bit          exp_halt;
        bit          exp_of;
        bit          exp_zf;
        logic [4:0]  ra;
        logic [17:0] exp_q[$];
        logic [17:0] got_q[$];

        n        = (len > DEPTH) ? DEPTH : len;
        exp_cnt  = 0;
        exp_halt = 1'b0;
        exp_of   = 1'b0;
        exp_zf   = 1'b0;
        for (int i = 0; i < n; i++) begin
            ra = (i == 0) ? prog_m[0][9:5] : prog_m[i-1][9:5];
            exp_q.push_back({prog_m[i][12:10], prog_m[i][9:5], ra, prog_m[i][4:0]});
            exp_cnt++;
            exp_of = exp_of | of_mask[i];
            exp_zf = zf_bits[i];
            if (HALT_EN && of_mask[i]) begin
                exp_halt = 1'b1;
                break;
            end
        end

        @(negedge clk);
        prog_len = len[PC_W-1:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            OF = (c < 32) ? of_mask[c] : 1'b0;
            ZF = (c < 32) ? zf_bits[c] : 1'b0;
            if (inject && c == 1) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = ~prog_m[1];
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            if (Write_Reg) begin
                got_q.push_back({ALU_OP, W_Addr, R_Addr_A, R_Addr_B});
                check({tag, "_busy"}, busy, 1'b1);
            end
            if (done) begin
                done_at = c;
                check({tag, "_done_cmd"}, {Write_Reg, busy, ALU_OP, W_Addr, R_Addr_A, R_Addr_B}, '0);
                if (n > 0) begin
                    check({tag, "_pc"}, pc, exp_cnt);
                    check({tag, "_of_seen"}, of_seen, exp_of);
                    check({tag, "_zf_last"}, zf_last, exp_zf);
                    check({tag, "_halted"}, halted, exp_halt);
                end
            end
            @(posedge clk);
            #1;
        end
        OF      = 1'b0;
        ZF      = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;

        check({tag, "_done_cycle"}, done_at, exp_cnt);
        check({tag, "_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_cmd%0d", tag, i), got_q[i], exp_q[i]);
        end
        check({tag, "_after_done"}, {done, busy, Write_Reg}, '0);
    endtask

    initial begin
        logic [31:0] ofm;
        int          len;
        bit          seen_bad;

        Reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        OF        = 1'b0;
        ZF        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {Write_Reg, busy, done, pc, ALU_OP, W_Addr, R_Addr_A, R_Addr_B, of_seen, zf_last, halted}, '0);
        @(negedge clk);
        Reset = 1'b0;

        // Fill the whole program so every entry the model reads is defined.
        for (int i = 0; i < DEPTH; i++) begin
            load_entry(i, 13'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            load_entry(i, {3'd3, 5'd1, 5'(i + 1)});
        end
        run_prog("chain3", 3, 32'h0, 32'h4, 1'b0);
        run_prog("len0", 0, 32'h0, 32'h0, 1'b0);
        run_prog("inject", 3, 32'h0, 32'h1, 1'b1);
        run_prog("after_inject", 3, 32'h0, 32'h0, 1'b0);
        run_prog("of_second", 4, 32'h2, 32'h8, 1'b0);
        run_prog("len20", 20, 32'h0, 32'h8000, 1'b0);

        // Reset asserted while the third command (pc = 2) is on the bus.
        @(negedge clk);
        prog_len = 5'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_pc", pc, 2);
        check("rst_mid_wr", Write_Reg, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_mid_outputs",
              {Write_Reg, busy, done, pc, ALU_OP, W_Addr, R_Addr_A, R_Addr_B, of_seen, zf_last, halted}, '0);
        @(negedge clk);
        Reset    = 1'b0;
        seen_bad = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy || Write_Reg) seen_bad = 1'b1;
        end
        check("rst_mid_no_done", seen_bad, 1'b0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                load_entry(i, 13'($urandom));
            end
            ofm = '0;
            for (int i = 0; i < 32; i++) begin
                ofm[i] = ($urandom_range(0, 7) == 0);
            end
            len = $urandom_range(0, 20);
            run_prog($sformatf("rand%0d", r), len, ofm, $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
